// File: rtl/systolic_feed_ctrl.sv
// Operand banks and skewed feed sequencer for a 4x4 output-stationary
// systolic array: loads A/B, then streams rows west and columns north.
module systolic_feed_ctrl #(
  parameter int DATA_W = 16,
  parameter int N      = 4,
  parameter int PE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic              busy,
  output logic              done,
  output logic              arr_rst,
  output logic [DATA_W-1:0] west0,
  output logic [DATA_W-1:0] west1,
  output logic [DATA_W-1:0] west2,
  output logic [DATA_W-1:0] west3,
  output logic [DATA_W-1:0] north0,
  output logic [DATA_W-1:0] north1,
  output logic [DATA_W-1:0] north2,
  output logic [DATA_W-1:0] north3
);

  localparam int FEED_LEN  = 2*N - 1;
  localparam int DRAIN_LEN = N - 1 + PE_LAT;
  localparam int TW        = $clog2(2*N + PE_LAT + 1);
  localparam int AW        = $clog2(N*N);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [TW-1:0] t_q;
  logic [TW-1:0] t_d;

  logic [DATA_W-1:0] a_bank [N*N];
  logic [DATA_W-1:0] b_bank [N*N];

  logic [DATA_W-1:0] west_q  [N];
  logic [DATA_W-1:0] west_d  [N];
  logic [DATA_W-1:0] north_q [N];
  logic [DATA_W-1:0] north_d [N];

  logic wr_err_q;
  logic feed_nxt;

  function automatic logic [AW-1:0] elem(int r, int c);
    return AW'(r*N + c);
  endfunction

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          t_d     = '0;
        end
      end
      CLEAR: begin
        state_d = FEED;
        t_d     = '0;
      end
      FEED: begin
        if (t_q == TW'(FEED_LEN-1)) begin
          state_d = DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      DRAIN: begin
        if (t_q == TW'(DRAIN_LEN-1)) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Outputs are registered, so the skew is computed from the next step.
  assign feed_nxt = (state_d == FEED);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      west_d[i]  = '0;
      north_d[i] = '0;
      if (feed_nxt && int'(t_d) >= i && int'(t_d) < i + N) begin
        west_d[i]  = a_bank[elem(i, int'(t_d) - i)];
        north_d[i] = b_bank[elem(int'(t_d) - i, i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      wr_err_q <= wr_en && (state_q != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        west_q[i]  <= '0;
        north_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        west_q[i]  <= west_d[i];
        north_q[i] <= north_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N*N; k++) begin
        a_bank[k] <= '0;
        b_bank[k] <= '0;
      end
    end else if (wr_en && state_q == IDLE) begin
      if (wr_sel) begin
        b_bank[wr_addr] <= wr_data;
      end else begin
        a_bank[wr_addr] <= wr_data;
      end
    end
  end

  assign wr_err  = wr_err_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign arr_rst = rst || (state_q == CLEAR);

  assign west0  = west_q[0];
  assign west1  = west_q[1];
  assign west2  = west_q[2];
  assign west3  = west_q[3];
  assign north0 = north_q[0];
  assign north1 = north_q[1];
  assign north2 = north_q[2];
  assign north3 = north_q[3];

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl, driving a behavioural 4x4
// output-stationary MAC array from the feed outputs.
module tb_systolic_feed_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wr_en;
  logic        wr_sel;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_err;
  logic        busy;
  logic        done;
  logic        arr_rst;
  logic [15:0] west0, west1, west2, west3;
  logic [15:0] north0, north1, north2, north3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  systolic_feed_ctrl #(.DATA_W(16), .N(4), .PE_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .busy(busy), .done(done), .arr_rst(arr_rst),
    .west0(west0), .west1(west1), .west2(west2), .west3(west3),
    .north0(north0), .north1(north1), .north2(north2), .north3(north3)
  );

  logic [15:0] wv [4];
  logic [15:0] nv [4];
  assign wv[0] = west0;
  assign wv[1] = west1;
  assign wv[2] = west2;
  assign wv[3] = west3;
  assign nv[0] = north0;
  assign nv[1] = north1;
  assign nv[2] = north2;
  assign nv[3] = north3;

  logic [15:0] ah  [4][4];
  logic [15:0] bv  [4][4];
  logic [31:0] acc [4][4];

  function automatic logic [15:0] a_in(int i, int j);
    return (j == 0) ? wv[i] : ah[i][j-1];
  endfunction

  function automatic logic [15:0] b_in(int i, int j);
    return (i == 0) ? nv[j] : bv[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ah[i][j]  <= arr_rst ? '0 : a_in(i, j);
        bv[i][j]  <= arr_rst ? '0 : b_in(i, j);
        acc[i][j] <= arr_rst ? '0 :
                     acc[i][j] + 32'(a_in(i, j)) * 32'(b_in(i, j));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(logic sel, int addr, int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 4'(addr);
    wr_data = 16'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_pass(string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    check({tag, "_done13"}, 32'(done), 32'd1);
    tick();
    check({tag, "_idle14"}, 32'(busy), 32'd0);
  endtask

  task automatic check_outs_zero(string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_west%0d", tag, i), 32'(wv[i]), 32'd0);
      check($sformatf("%s_north%0d", tag, i), 32'(nv[i]), 32'd0);
    end
  endtask

  int dcount;

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0;
    wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_arr_rst", 32'(arr_rst), 32'd1);
    check_outs_zero("rst");
    rst = 1'b0;
    tick();
    check("idle_arr_rst", 32'(arr_rst), 32'd0);

    // Skew pattern: A[i][k]=16i+k, B[k][j]=k+j
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wr(1'b0, r*4+c, 16*r+c);
        wr(1'b1, r*4+c, r+c);
      end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      check($sformatf("skew_west2_c%0d", c), 32'(west2),
            (c >= 4 && c <= 7) ? 32'(32 + c - 4) : 32'd0);
      check($sformatf("skew_north3_c%0d", c), 32'(north3),
            (c >= 5 && c <= 8) ? 32'(c - 2) : 32'd0);
      check($sformatf("skew_done_c%0d", c), 32'(done),
            (c == 13) ? 32'd1 : 32'd0);
      check($sformatf("skew_busy_c%0d", c), 32'(busy), 32'd1);
      check($sformatf("skew_arr_rst_c%0d", c), 32'(arr_rst),
            (c == 1) ? 32'd1 : 32'd0);
      if (c < 13) tick();
    end
    tick();
    check("skew_idle", 32'(busy), 32'd0);
    check_outs_zero("skew_idle");

    // All ones times all twos, twice without rewriting
    for (int k = 0; k < 16; k++) begin
      wr(1'b0, k, 1);
      wr(1'b1, k, 2);
    end
    run_pass("ones1");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("ones1_acc%0d%0d", i, j), acc[i][j], 32'd8);
    run_pass("ones2");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("ones2_acc%0d%0d", i, j), acc[i][j], 32'd8);

    // Identity times B, with a rejected mid-pass write
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wr(1'b0, r*4+c, (r == c) ? 1 : 0);
        wr(1'b1, r*4+c, 4*r+c+1);
      end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = 16'hFFFF;
    tick();
    wr_en = 1'b0;
    check("busywr_err_c5", 32'(wr_err), 32'd1);
    tick();
    check("busywr_err_c6", 32'(wr_err), 32'd0);
    repeat (7) tick();
    check("ident_done13", 32'(done), 32'd1);
    tick();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("ident_acc%0d%0d", i, j), acc[i][j], 32'(4*i+j+1));
    run_pass("ident2");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("ident2_acc%0d%0d", i, j), acc[i][j], 32'(4*i+j+1));

    // Write alongside start: A[0][0]=2 must be used by this pass
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'd2;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    repeat (12) tick();
    check("wrstart_done13", 32'(done), 32'd1);
    tick();
    for (int j = 0; j < 4; j++)
      check($sformatf("wrstart_acc0%0d", j), acc[0][j], 32'(2*(j+1)));
    check("wrstart_acc11", acc[1][1], 32'd6);

    // Reset mid-pass
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort_busy_c6", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_arr_rst", 32'(arr_rst), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_wr_err", 32'(wr_err), 32'd0);
    check("abort_arr_rst_off", 32'(arr_rst), 32'd0);
    check_outs_zero("abort");
    dcount = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    run_pass("after_abort");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("cleared_acc%0d%0d", i, j), acc[i][j], 32'd0);

    // Start held high: back-to-back passes, 14-cycle period
    start = 1'b1;
    tick();
    for (int c = 1; c <= 41; c++) begin
      check($sformatf("hold_done_c%0d", c), 32'(done),
            (c % 14 == 13) ? 32'd1 : 32'd0);
      check($sformatf("hold_busy_c%0d", c), 32'(busy),
            (c % 14 == 0) ? 32'd0 : 32'd1);
      if (c < 41) tick();
    end
    start = 1'b0;
    tick();
    tick();
    check("hold_stop_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
